// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one bit per clock.
// Divide-by-zero and signed overflow resolve in a single cycle.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] sh_lo;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quot_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      quot_q   <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    // The shifted remainder's top bit acts as the borrow guard
    sh_lo   = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    ge      = {rem_q[WIDTH-1], sh_lo} >= {1'b0, div_q};
    rem_nx  = ge ? (sh_lo - div_q) : sh_lo;
    quot_nx = {quot_q[WIDTH-2:0], ge};
    q_fix   = q_neg_q ? (-quot_nx) : quot_nx;
    r_fix   = r_neg_q ? (-rem_nx) : rem_nx;

    sgn   = ~func[0];
    a_neg = sgn & opA[WIDTH-1];
    b_neg = sgn & opB[WIDTH-1];
    ovf   = sgn && (opA == MIN_NEG) && (opB == '1);

    unique case (state_q)
      IDLE: begin
        if (start && func[2]) begin
          is_rem_d = func[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          if (opB == '0) begin
            result_d = func[1] ? opA : '1;
            state_d  = FIN;
          end else if (ovf) begin
            result_d = func[1] ? '0 : opA;
            state_d  = FIN;
          end else begin
            quot_d  = a_neg ? (-opA) : opA;
            div_d   = b_neg ? (-opB) : opB;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = is_rem_q ? r_fix : q_fix;
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: results, latency,
// ignored requests, and asynchronous reset abort.
module tb_iterative_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;
  int n;

  iterative_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input int lat);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    opA   = $urandom;
    opB   = $urandom;
    func  = 3'($urandom);
    n = 1;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    wait_done();
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".res"}, result, exp);
    @(posedge clk);
    #1;
    chk({tag, ".dn0"}, {31'd0, done}, 32'd0);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    func  = 3'b000;
    opA   = '0;
    opB   = '0;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.res", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("divu100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("rem7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    do_op("div_m100_m7", 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
    do_op("rem_m100_m7", 3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
    do_op("remu_big_16", 3'b111, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    do_op("divu5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    do_op("div0_0", 3'b100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    @(negedge clk);
    start = 1'b1;
    func  = 3'b101;
    opA   = 32'd1000;
    opB   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    opA   = 32'd50;
    opB   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 5;
    #6;
    wait_done();
    chk("ign.lat", n, 33);
    chk("ign.res", result, 32'd333);
    start = 1'b1;
    opA   = 32'd9;
    opB   = 32'd3;
    @(posedge clk);
    #1;
    chk("fin_start.busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    chk("fin_start.res", result, 32'd333);

    @(negedge clk);
    start = 1'b1;
    func  = 3'b000;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("f000.busy", {31'd0, busy}, 32'd0);
    chk("f000.done", {31'd0, done}, 32'd0);

    @(negedge clk);
    start = 1'b1;
    func  = 3'b101;
    opA   = 32'd1000;
    opB   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    chk("arst.res", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.nodone", {31'd0, done}, 32'd0);

    do_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
